sgbus_rx_pkt_gate: RTL and testbench

- Store-and-forward ingress gate on the Aurora RX stream. Sits directly upstream of the AXI-Lite mapping stage and feeds its s_axis input.
- Accepts SGBUS packets: one header beat plus pkt_len payload beats.
- Validates each header and buffers the whole packet. Only complete, well-formed packets are released downstream.
- Malformed, unknown-type and stalled (timed-out) packets are discarded and counted, so the mapping stage never sees partial or corrupt frames.

---
 rtl/sgbus_pkg.sv | 39 +++
 rtl/sgbus_idle_timer.sv | 30 +++
 rtl/sgbus_rx_pkt_gate.sv | 182 ++++++++++++++++++
 tb/tb_sgbus_rx_pkt_gate.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgbus_pkg.sv
// SGBUS ingress packet gate: shared header layout, magic value and enum types.
// Also used by the downstream AXI-Lite mapping stage.
package sgbus_pkg;

    localparam int          HdrMagicLsb = 112;
    localparam int          HdrTypeLsb  = 64;
    localparam int          HdrLenLsb   = 0;
    localparam logic [15:0] SgbusMagic  = 16'h4859;

    typedef enum logic [15:0] {
        PKT_AXIL_RD = 16'd0,
        PKT_AXIL_WR = 16'd1
    } pkt_type_e;

    typedef enum logic [1:0] {
        DROP_BAD_MAGIC = 2'd0,
        DROP_BAD_LEN   = 2'd1,
        DROP_BAD_TYPE  = 2'd2,
        DROP_TIMEOUT   = 2'd3
    } drop_cause_e;

    typedef enum logic [1:0] {
        GATE_IDLE,
        GATE_COLLECT,
        GATE_DISCARD,
        GATE_RELEASE
    } gate_state_e;

    typedef struct packed {
        logic [15:0] magic;
        logic [15:0] type_id;
        logic [15:0] len;
    } sgbus_hdr_t;

    function automatic logic type_known(input logic [15:0] t);
        return (t == PKT_AXIL_RD) || (t == PKT_AXIL_WR);
    endfunction

endpackage

// File: rtl/sgbus_idle_timer.sv
// Idle-cycle watchdog: counts armed cycles without activity and strobes
// once when TimeoutCycles consecutive idle cycles have elapsed.
module sgbus_idle_timer #(
    parameter int TimeoutCycles = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);
    localparam int              CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Activity in the would-be expiry cycle wins over the timeout.
    assign expire_o = run_i && !clear_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!run_i || clear_i || expire_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sgbus_rx_pkt_gate.sv
// Store-and-forward ingress gate: validates SGBUS headers, buffers whole
// packets and releases only complete, well-formed ones downstream.
module sgbus_rx_pkt_gate
    import sgbus_pkg::*;
#(
    parameter int          DataWidth     = 128,
    parameter int          MaxPayload    = 3,
    parameter int          TimeoutCycles = 1024,
    parameter logic [15:0] Magic         = SgbusMagic
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [DataWidth-1:0] s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DataWidth-1:0] m_axis_tdata,
    output logic                 drop_pulse,
    output logic [1:0]           drop_cause,
    output logic [15:0]          drop_cnt
);
    localparam int          Depth  = MaxPayload + 1;
    localparam int          PtrW   = $clog2(Depth);
    localparam logic [15:0] MaxLen = 16'(MaxPayload);

    gate_state_e          state_q;
    logic [DataWidth-1:0] buf_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, remaining_q, len_q;
    logic                 s_ready_q, m_valid_q;
    logic [DataWidth-1:0] m_data_q;
    logic                 drop_pulse_q;
    drop_cause_e          drop_cause_q;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    sgbus_hdr_t      hdr;
    logic            s_fire, m_fire;
    logic            hdr_len_ok, hdr_accept, hdr_keep;
    logic            timer_run, timer_expire;
    logic            drop_ev;
    drop_cause_e     drop_ev_cause;
    logic            buf_we;
    logic [PtrW-1:0] buf_waddr, rd_ptr_nxt;

    assign hdr.magic   = s_axis_tdata[HdrMagicLsb +: 16];
    assign hdr.type_id = s_axis_tdata[HdrTypeLsb +: 16];
    assign hdr.len     = s_axis_tdata[HdrLenLsb +: 16];

    assign s_fire     = s_axis_tvalid && s_ready_q;
    assign m_fire     = m_valid_q && m_axis_tready;
    assign hdr_len_ok = (hdr.len != 16'd0) && (hdr.len <= MaxLen);
    assign hdr_accept = (hdr.magic == Magic) && hdr_len_ok;
    assign hdr_keep   = hdr_accept && type_known(hdr.type_id);
    assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

    assign timer_run = (state_q == GATE_COLLECT) || (state_q == GATE_DISCARD);

    sgbus_idle_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .run_i    (timer_run),
        .clear_i  (s_fire),
        .expire_o (timer_expire)
    );

    // Unknown-type packets are reported once on entry to DISCARD, so a later
    // DISCARD timeout stays silent.
    always_comb begin
        drop_ev       = 1'b0;
        drop_ev_cause = DROP_BAD_MAGIC;
        if (state_q == GATE_IDLE && s_fire) begin
            if (hdr.magic != Magic) begin
                drop_ev       = 1'b1;
                drop_ev_cause = DROP_BAD_MAGIC;
            end else if (!hdr_len_ok) begin
                drop_ev       = 1'b1;
                drop_ev_cause = DROP_BAD_LEN;
            end else if (!type_known(hdr.type_id)) begin
                drop_ev       = 1'b1;
                drop_ev_cause = DROP_BAD_TYPE;
            end
        end else if (state_q == GATE_COLLECT && timer_expire) begin
            drop_ev       = 1'b1;
            drop_ev_cause = DROP_TIMEOUT;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_ev && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    assign buf_we    = s_fire && ((state_q == GATE_IDLE && hdr_keep) || state_q == GATE_COLLECT);
    assign buf_waddr = (state_q == GATE_IDLE) ? '0 : wr_ptr_q;

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[buf_waddr] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= GATE_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            drop_pulse_q <= 1'b0;
            drop_cause_q <= DROP_BAD_MAGIC;
            drop_cnt_q   <= '0;
        end else begin
            drop_pulse_q <= drop_ev;
            drop_cnt_q   <= drop_cnt_d;
            if (drop_ev) drop_cause_q <= drop_ev_cause;

            unique case (state_q)
                GATE_IDLE: begin
                    if (s_fire && hdr_accept) begin
                        remaining_q <= hdr.len[PtrW-1:0];
                        len_q       <= hdr.len[PtrW-1:0];
                        if (hdr_keep) begin
                            wr_ptr_q <= PtrW'(1);
                            state_q  <= GATE_COLLECT;
                        end else begin
                            state_q  <= GATE_DISCARD;
                        end
                    end
                end
                GATE_COLLECT: begin
                    if (s_fire) begin
                        wr_ptr_q    <= wr_ptr_q + PtrW'(1);
                        remaining_q <= remaining_q - PtrW'(1);
                        // Header sits in buf_q[0] already; preload it so the
                        // first beat is valid the cycle after the last write.
                        if (remaining_q == PtrW'(1)) begin
                            state_q   <= GATE_RELEASE;
                            rd_ptr_q  <= '0;
                            m_data_q  <= buf_q[0];
                            s_ready_q <= 1'b0;
                            m_valid_q <= 1'b1;
                        end
                    end else if (timer_expire) begin
                        state_q <= GATE_IDLE;
                    end
                end
                GATE_DISCARD: begin
                    if (s_fire) begin
                        remaining_q <= remaining_q - PtrW'(1);
                        if (remaining_q == PtrW'(1)) state_q <= GATE_IDLE;
                    end else if (timer_expire) begin
                        state_q <= GATE_IDLE;
                    end
                end
                GATE_RELEASE: begin
                    if (m_fire) begin
                        rd_ptr_q <= rd_ptr_nxt;
                        if (rd_ptr_q == len_q) begin
                            state_q   <= GATE_IDLE;
                            s_ready_q <= 1'b1;
                            m_valid_q <= 1'b0;
                        end else begin
                            m_data_q  <= buf_q[rd_ptr_nxt];
                        end
                    end
                end
                default: state_q <= GATE_IDLE;
            endcase
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign drop_pulse    = drop_pulse_q;
    assign drop_cause    = drop_cause_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_sgbus_rx_pkt_gate.sv
// Bench for sgbus_rx_pkt_gate: packet-level queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sgbus_rx_pkt_gate;
    localparam int DW   = 128;
    localparam int MAXP = 3;
    localparam int TO   = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid, s_tready, m_tvalid, m_tready, drop_pulse;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [1:0]    drop_cause;
    logic [15:0]   drop_cnt;

    sgbus_rx_pkt_gate #(
        .DataWidth(DW), .MaxPayload(MAXP), .TimeoutCycles(TO), .Magic(16'h4859)
    ) dut (
        .clk(clk), .reset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .drop_pulse(drop_pulse), .drop_cause(drop_cause), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packet-level model: beats of the packet being received and the queue of
    // beats still owed downstream.
    logic [127:0] m_cur[$];
    logic [127:0] m_out[$];
    bit           in_pkt, keep;
    int           need, idle;
    bit           e_pulse;
    logic [1:0]   e_cause;
    logic [15:0]  e_cnt;

    logic [127:0] got[$];
    int           n_stall, n_pulse;
    bit           chk_en = 1'b0;

    task automatic m_drop(input logic [1:0] c);
        e_pulse = 1'b1;
        e_cause = c;
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    endtask

    always @(posedge clk) begin : model
        logic        acc;
        logic [15:0] mg, ty, ln;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) got.push_back(m_tdata);
        if (s_tready === 1'b0) n_stall++;
        if (drop_pulse === 1'b1) n_pulse++;
        if (rst) begin
            m_cur.delete(); m_out.delete();
            in_pkt = 0; keep = 0; need = 0; idle = 0;
            e_pulse = 0; e_cause = 2'd0; e_cnt = 16'd0;
        end else begin
            e_pulse = 0;
            acc = s_tvalid && (m_out.size() == 0);
            if (m_out.size() != 0 && m_tready) void'(m_out.pop_front());
            if (acc && !in_pkt) begin
                mg = s_tdata[127:112]; ty = s_tdata[79:64]; ln = s_tdata[15:0];
                if (mg != 16'h4859) m_drop(2'd0);
                else if (ln == 16'd0 || ln > 16'(MAXP)) m_drop(2'd1);
                else begin
                    in_pkt = 1; need = int'(ln); idle = 0;
                    keep = (ty == 16'd0 || ty == 16'd1);
                    m_cur.delete();
                    if (keep) m_cur.push_back(s_tdata);
                    else      m_drop(2'd2);
                end
            end else if (acc) begin
                idle = 0;
                need--;
                if (keep) m_cur.push_back(s_tdata);
                if (need == 0) begin
                    in_pkt = 0;
                    if (keep) m_out = m_cur;
                end
            end else if (in_pkt) begin
                idle++;
                if (idle == TO) begin
                    in_pkt = 0;
                    if (keep) m_drop(2'd3);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_axis_tready", 128'(s_tready), 128'(m_out.size() == 0));
            chk("m_axis_tvalid", 128'(m_tvalid), 128'(m_out.size() != 0));
            if (m_out.size() != 0) chk("m_axis_tdata", m_tdata, m_out[0]);
            chk("drop_pulse", 128'(drop_pulse), 128'(e_pulse));
            chk("drop_cause", 128'(drop_cause), 128'(e_cause));
            chk("drop_cnt", 128'(drop_cnt), 128'(e_cnt));
        end
    end

    // Downstream ready: 0 always, 1 random, 2 scripted pattern during release, 3 manual.
    int rdy_mode = 0;
    int pidx = 0;
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    always @(negedge clk) begin
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = ($urandom_range(0, 2) != 0);
            2: begin
                if (m_tvalid) begin
                    m_tready = (pidx < 5) ? pat[pidx] : 1'b1;
                    pidx++;
                end else m_tready = 1'b0;
            end
            default: ;
        endcase
    end

    function automatic logic [127:0] mk_hdr(input logic [15:0] mg, input logic [15:0] ty,
                                            input logic [15:0] ln, input logic [79:0] fill);
        return {mg, fill[79:48], ty, fill[47:0], ln};
    endfunction

    task automatic send(input logic [127:0] d);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        while (s_tready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL send_wait: tready stuck at %b, required 1", s_tready);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(s_tready === 1'b1 && m_tvalid === 1'b0) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_wait: tvalid=%b tready=%b, required 0/1", m_tvalid, s_tready);
        end
    endtask

    task automatic check_got(input string nm, input int n,
                             input logic [127:0] e0, input logic [127:0] e1, input logic [127:0] e2);
        logic [127:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({nm, "_count"}, 128'(got.size()), 128'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk($sformatf("%s_beat%0d", nm, i), got[i], e[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [127:0] hw, hr, hx, pl;
        logic [15:0]  mg, ty, ln;
        int           kind;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_tready", 128'(s_tready), 128'(1));
        chk("rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_tdata", m_tdata, 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write packet, back-to-back, downstream always ready
        hw = 128'h4859_0000_0000_0001_0000_0000_0000_0002;
        got.delete(); n_stall = 0;
        send(hw); send(128'h10); send(128'hAB);
        chk("wr_latency_tvalid", 128'(m_tvalid), 128'(1));
        drain(); repeat (2) @(negedge clk);
        check_got("wr_pkt", 3, hw, 128'h10, 128'hAB);
        chk("wr_stall_cycles", 128'(n_stall), 128'(3));
        chk("wr_drop_cnt", 128'(drop_cnt), 128'(0));

        // Same packet under scripted backpressure 1,0,0,1,1
        rdy_mode = 2; pidx = 0; got.delete(); n_stall = 0;
        send(hw); send(128'h10); send(128'hAB);
        drain(); repeat (2) @(negedge clk);
        rdy_mode = 0;
        check_got("bp_pkt", 3, hw, 128'h10, 128'hAB);
        chk("bp_stall_cycles", 128'(n_stall), 128'(5));

        // Bad magic then a valid read packet
        hr = mk_hdr(16'h4859, 16'd0, 16'd1, 80'h0);
        got.delete(); n_pulse = 0;
        send(mk_hdr(16'h1234, 16'd1, 16'd2, 80'h0)); send(hr); send(128'hA5);
        drain(); repeat (2) @(negedge clk);
        chk("magic_pulses", 128'(n_pulse), 128'(1));
        chk("magic_cause", 128'(drop_cause), 128'(0));
        chk("magic_cnt", 128'(drop_cnt), 128'(1));
        check_got("magic_next", 2, hr, 128'hA5, 128'h0);

        // Unknown type: two beats swallowed (one looks like a header)
        hx = mk_hdr(16'h4859, 16'd1, 16'd1, 80'h0);
        got.delete();
        send(mk_hdr(16'h4859, 16'd5, 16'd2, 80'h0)); send(hx); send(128'h77);
        send(hx); send(128'hCC);
        drain(); repeat (2) @(negedge clk);
        chk("type_cause", 128'(drop_cause), 128'(2));
        chk("type_cnt", 128'(drop_cnt), 128'(2));
        check_got("type_next", 2, hx, 128'hCC, 128'h0);

        // Length beyond MaxPayload
        send(mk_hdr(16'h4859, 16'd0, 16'd4, 80'h0));
        repeat (2) @(negedge clk);
        chk("len_cause", 128'(drop_cause), 128'(1));
        chk("len_cnt", 128'(drop_cnt), 128'(3));
        chk("len_tready", 128'(s_tready), 128'(1));

        // Collect timeout after one of two payload beats
        send(mk_hdr(16'h4859, 16'd1, 16'd2, 80'h0)); send(128'h11);
        repeat (TO - 1) @(negedge clk);
        chk("to_pulse_early", 128'(drop_pulse), 128'(0));
        @(negedge clk);
        chk("to_pulse", 128'(drop_pulse), 128'(1));
        chk("to_cause", 128'(drop_cause), 128'(3));
        chk("to_cnt", 128'(drop_cnt), 128'(4));
        got.delete();
        send(hr); send(128'h22);
        drain(); repeat (2) @(negedge clk);
        check_got("to_next", 2, hr, 128'h22, 128'h0);

        // Discard timeout reports nothing further
        send(mk_hdr(16'h4859, 16'd9, 16'd3, 80'h0)); send(128'h33);
        repeat (TO + 6) @(negedge clk);
        chk("dto_cnt", 128'(drop_cnt), 128'(5));
        chk("dto_cause", 128'(drop_cause), 128'(2));

        // Randomized traffic
        rdy_mode = 1;
        for (int p = 0; p < 200; p++) begin
            kind = $urandom_range(0, 9);
            mg = 16'h4859; ty = 16'($urandom_range(0, 1)); ln = 16'($urandom_range(1, MAXP));
            if (kind == 0) begin
                mg = 16'($urandom);
                if (mg == 16'h4859) mg = 16'h4858;
            end else if (kind == 1) begin
                case ($urandom_range(0, 3))
                    0: ln = 16'd0;
                    1: ln = 16'($urandom_range(4, 255));
                    2: ln = 16'hFFFF;
                    default: ln = 16'h0100 | 16'($urandom_range(1, 3));
                endcase
            end else if (kind == 2) begin
                ty = 16'($urandom_range(2, 65535));
            end
            send(mk_hdr(mg, ty, ln, {$urandom, $urandom, 16'($urandom)}));
            if (kind > 1) begin
                for (int b = 0; b < int'(ln); b++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    pl = {$urandom, $urandom, $urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) pl[127:112] = 16'h4859;
                    send(pl);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain(); repeat (3) @(negedge clk);

        // Reset while beat 1 of a release is on the bus
        rdy_mode = 3;
        @(negedge clk);
        m_tready = 1'b0;
        send(mk_hdr(16'h4859, 16'd1, 16'd2, 80'h0)); send(128'h33); send(128'h44);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        chk("rr_beat1", m_tdata, 128'h33);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_tvalid", 128'(m_tvalid), 128'(0));
        chk("rr_tready", 128'(s_tready), 128'(1));
        chk("rr_cnt", 128'(drop_cnt), 128'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_cnt_after", 128'(drop_cnt), 128'(0));
        chk("rr_pulse_after", 128'(drop_pulse), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
